// File: rtl/dpram_reader.sv
// dpram_reader: block read sequencer for the dual-port sample RAM, valid/ready output stream
// Ports: ck/rst_n clock and async active-low reset; start/start_addr/length block command;
//   abort flush; busy/done status; re/raddr/rdata RAM read port (1-cycle read latency);
//   out_valid/out_ready/out_data/out_last output stream.
// Optional: DPRAM_READER_STRIDE_EN adds the stride input (address step per read, latched with start).
module dpram_reader #(
  parameter int BITS = 16,
  parameter int SIZE = 256,
  parameter int AWIDTH = $clog2(SIZE),
  parameter int CWIDTH = AWIDTH + 1
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AWIDTH-1:0] start_addr,
  input  logic [CWIDTH-1:0] length,
`ifdef DPRAM_READER_STRIDE_EN
  input  logic [AWIDTH-1:0] stride,
`endif
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              re,
  output logic [AWIDTH-1:0] raddr,
  input  logic [BITS-1:0]   rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS-1:0]   out_data,
  output logic              out_last
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, nxt;
  logic [AWIDTH-1:0] addr, step;
  logic [CWIDTH-1:0] rem;
  logic [BITS-1:0] mem [4];
  logic [3:0] lst;
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic infl, infl_last, pop, take;
  assign busy = state != IDLE;
  assign take = state == IDLE && start && !abort;
  assign out_valid = cnt != 3'd0;
  assign out_data = mem[rp];
  assign out_last = out_valid && lst[rp];
  assign pop = out_valid && out_ready;
  assign raddr = addr;
  // occupancy counts FIFO entries plus the read still in flight; the word popped this cycle frees a slot
  assign re = state == RUN && ({1'b0, cnt} + {3'b0, infl} < 4'd4 + {3'b0, pop});
  always_comb begin
    nxt = abort ? IDLE :
          state == IDLE && start && length != '0 ? RUN :
          state == RUN && re && rem == CWIDTH'(1) ? DRAIN :
          state == DRAIN && pop && out_last ? IDLE : state;
  end
`ifdef DPRAM_READER_STRIDE_EN
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) step <= '0;
    else if (take) step <= stride;
`else
  assign step = AWIDTH'(1);
`endif
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      infl <= 1'b0;
      infl_last <= 1'b0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      lst <= '0;
      addr <= '0;
      rem <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      state <= nxt;
      done <= !abort && ((state == IDLE && start && length == '0) || (state == DRAIN && pop && out_last));
      infl <= re && !abort;
      infl_last <= rem == CWIDTH'(1);
      if (abort) begin
        cnt <= '0;
        wp <= '0;
        rp <= '0;
      end else begin
        if (infl) begin
          mem[wp] <= rdata;
          lst[wp] <= infl_last;
          wp <= wp + 2'd1;
        end
        if (pop) rp <= rp + 2'd1;
        cnt <= cnt + {2'b0, infl} - {2'b0, pop};
      end
      if (take) begin
        addr <= start_addr;
        rem <= length;
      end else if (re) begin
        addr <= addr + step;
        rem <= rem - CWIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_dpram_reader.sv
// tb_dpram_reader: directed self-checking bench for dpram_reader
module tb_dpram_reader;
  logic ck = 0, rst_n = 0, start = 0, abort = 0, out_ready = 0;
  logic [7:0] start_addr = 0;
  logic [8:0] length = 0;
  logic busy, done, re, out_valid, out_last;
  logic [7:0] raddr;
  logic [15:0] rdata = 0, out_data;
  logic [15:0] ram [256];
  int checks = 0, failures = 0, first, lastc;
`ifdef DPRAM_READER_STRIDE_EN
  logic [7:0] stride = 8'd1;
`endif
  dpram_reader dut (
    .ck(ck), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
`ifdef DPRAM_READER_STRIDE_EN
    .stride(stride),
`endif
    .abort(abort), .busy(busy), .done(done), .re(re), .raddr(raddr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );
  always #5 ck = ~ck;
  always @(posedge ck) if (re) rdata <= ram[raddr];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [7:0] a, input logic [8:0] n);
    @(negedge ck);
    start = 1; start_addr = a; length = n; out_ready = 1;
  endtask
  task automatic run_block(input int n, input int a0, input int st, input bit bp, input int inj,
                           output int f, output int l);
    int cyc = 0, iss = 0, acc = 0;
    logic pv = 0, pr = 0;
    logic [15:0] pd = 0;
    logic [7:0] ea;
    f = -1; l = -1;
    while (acc < n && cyc < 300) begin
      @(negedge ck);
      start = (cyc + 1 == inj);
      if (start) begin start_addr = 8'h80; length = 9'd3; end
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1; cyc++;
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
      end
      if (re) begin
        ea = 8'(a0 + st * iss);
        chk("raddr", raddr, ea);
        chk("occupancy", (iss - acc - int'(out_valid & out_ready)) < 4, 1);
        iss++;
      end
      if (out_valid && out_ready) begin
        ea = 8'(a0 + st * acc);
        chk("data", out_data, ea);
        chk("last", out_last, acc == n - 1);
        if (f < 0) f = cyc;
        l = cyc;
        acc++;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
    end
    chk("words", acc, n);
    chk("reads", iss, n);
    @(negedge ck); start = 0; #1;
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("valid_end", out_valid, 0);
    @(negedge ck); #1;
    chk("done_once", done, 0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i);
    #2;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_re", re, 0);
    chk("rst_valid", out_valid, 0); chk("rst_last", out_last, 0);
    chk("rst_raddr", raddr, 0); chk("rst_data", out_data, 0);
    @(negedge ck); rst_n = 1;
    go(8'h10, 9'd8);
    run_block(8, 'h10, 1, 0, 0, first, lastc);
    chk("basic_first", first, 3);
    chk("basic_last_cyc", lastc, 10);
    go(8'hFE, 9'd4);
    run_block(4, 'hFE, 1, 0, 0, first, lastc);
    chk("wrap_first", first, 3);
    go(8'h30, 9'd16);
    run_block(16, 'h30, 1, 1, 0, first, lastc);
    go(8'h00, 9'd0);
    #1; chk("zero_re", re, 0);
    @(negedge ck); start = 0; #1;
    chk("zero_done", done, 1); chk("zero_busy", busy, 0); chk("zero_re2", re, 0);
    @(negedge ck); #1;
    chk("zero_done_once", done, 0); chk("zero_re3", re, 0);
    go(8'h50, 9'd8);
    run_block(8, 'h50, 1, 0, 4, first, lastc);
    chk("busy_start_last_cyc", lastc, 10);
    go(8'h40, 9'd8);
    for (int i = 1; i <= 5; i++) begin
      @(negedge ck); start = 0; abort = (i == 5); #1;
    end
    chk("abort_valid", out_valid, 1);
    chk("abort_word", out_data, 16'h42);
    @(negedge ck); abort = 0; #1;
    chk("abort_out_valid", out_valid, 0); chk("abort_busy", busy, 0);
    chk("abort_re", re, 0); chk("abort_done", done, 0);
    @(negedge ck); #1;
    chk("abort_done2", done, 0); chk("abort_valid2", out_valid, 0);
    go(8'h20, 9'd5);
    run_block(5, 'h20, 1, 0, 0, first, lastc);
    chk("post_abort_first", first, 3);
    go(8'h60, 9'd8);
    for (int i = 1; i <= 4; i++) begin
      @(negedge ck); start = 0; #1;
    end
    chk("mid_valid", out_valid, 1);
    rst_n = 0; #1;
    chk("mrst_busy", busy, 0); chk("mrst_done", done, 0); chk("mrst_re", re, 0);
    chk("mrst_valid", out_valid, 0); chk("mrst_last", out_last, 0);
    chk("mrst_raddr", raddr, 0); chk("mrst_data", out_data, 0);
    @(negedge ck); rst_n = 1;
    @(negedge ck); #1;
    chk("mrst_done2", done, 0); chk("mrst_busy2", busy, 0);
    go(8'h70, 9'd3);
    run_block(3, 'h70, 1, 0, 0, first, lastc);
`ifdef DPRAM_READER_STRIDE_EN
    @(negedge ck);
    start = 1; start_addr = 8'hF0; length = 9'd4; stride = 8'h08; out_ready = 1;
    run_block(4, 'hF0, 8, 0, 0, first, lastc);
    go(8'h05, 9'd3);
    stride = 8'h00;
    run_block(3, 'h05, 0, 0, 0, first, lastc);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dpram_reader.md
Name: dpram_reader

Overview:
- Read-side sequencer for the team's dual-port sample RAM.
- On a start command it fetches a block of words starting at a given address and wraps modulo SIZE.
- It drives the RAM read port (re/raddr) and absorbs the RAM's 1-cycle registered read latency in a small internal FIFO.
- It presents the words on a valid/ready stream with full back-pressure, for FIR tap fetch, playback and delay-line readout.

Parameters:
- BITS, 16, data word width; must match the RAM.
- SIZE, 256, RAM depth in words; power of two.
- AWIDTH, $clog2(SIZE), RAM address width.
- CWIDTH, AWIDTH+1, block length width; lengths 0..SIZE are legal.

Ports:
- ck  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  start-command pulse; honoured only while busy=0.
- start_addr  in  AWIDTH  first word address; latched with start.
- length  in  CWIDTH  number of words to read; latched with start.
- abort  in  1  synchronous flush of the current block.
- busy  out  1  high from the cycle after an accepted start until done or abort.
- done  out  1  one-cycle pulse after the last word is accepted.
- re  out  1  RAM read enable.
- raddr  out  AWIDTH  RAM read address.
- rdata  in  BITS  RAM read data; valid the cycle after re.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  BITS  stream data; driven from the FIFO head.
- out_last  out  1  marks the final word of the block.

Behaviour:
- Reset: busy, done, re, out_valid and out_last are 0; raddr=0; out_data=0; FIFO empty; remaining count=0.
- States:
  - IDLE: waits for start.
  - RUN: reads are still being issued.
  - DRAIN: all reads issued; waits for the FIFO and in-flight reads to empty.
- IDLE->RUN: start=1 and length!=0.
- IDLE with start=1 and length=0: stays IDLE, issues no reads, pulses done in the next cycle, busy stays 0.
- RUN->DRAIN: when the last read is issued.
- DRAIN->IDLE: when the word with out_last is accepted (out_valid & out_ready); done=1 in the following cycle.
- Internal FIFO:
  - Depth 4.
  - Occupancy = FIFO entries + reads issued but not yet written.
  - A read is issued (re=1) in a RUN cycle only when occupancy minus the current-cycle pop is less than 4.
  - This sustains 1 word/cycle while out_ready is held high.
- Read timing: a read issued in cycle N captures rdata into the FIFO at the end of N+1 and can appear on out_data in N+2.
- Latency: start accepted at edge E; first re in the cycle after E; first out_valid 3 cycles after E.
- Addressing:
  - raddr starts at start_addr and increments by 1 per issued read, modulo SIZE (SIZE-1 wraps to 0).
  - raddr holds its value while re=0.
- out_last is asserted with the final word only.
- Stream rule: out_valid must stay high and out_data stable until accepted.
- start while busy=1: ignored; latched values are unchanged.
- abort (any state): in the next cycle, FIFO cleared, in-flight reads discarded, re=0, out_valid=0, state=IDLE, busy=0, no done pulse.
- abort and start in the same cycle: abort wins; the start is dropped.
- rst_n low mid-block: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: DPRAM_READER_STRIDE_EN.
- With the macro:
  - Adds input port stride [AWIDTH-1:0], latched with start.
  - raddr advances by the latched stride per issued read, modulo SIZE.
  - stride=0 repeatedly reads start_addr for length words.
- Without the macro: no stride port; increment is fixed at 1.

Test Plan:
- Basic block: start_addr=0x10, length=8, RAM[i]=i, out_ready=1.
  - Expect 0x10..0x17 on consecutive cycles; first out_valid 3 cycles after start.
  - out_last on 0x17; done 1 cycle later; busy high throughout.
- Wrap: SIZE=256, start_addr=0xFE, length=4.
  - Expect raddr sequence 0xFE,0xFF,0x00,0x01 and data in the same order.
- Back-pressure: length=16, out_ready toggled by a random 50% pattern.
  - Expect all 16 words in order, none lost or duplicated.
  - re never issued with occupancy 4.
  - out_data stable while out_valid & !out_ready.
- Zero length and busy start:
  - length=0: expect no re and a done pulse in the next cycle.
  - start during a length=8 run: expect it ignored; exactly 8 words output.
- Abort and reset:
  - abort at the 3rd output word: expect out_valid=0, busy=0 next cycle, no done; a following start runs cleanly.
  - rst_n low mid-block: all outputs at reset values at once.
- Stride (with DPRAM_READER_STRIDE_EN): start_addr=0xF0, stride=0x08, length=4.
  - Expect raddr 0xF0,0xF8,0x00,0x08.
